// File: rtl/add_seq64.sv
// add_seq64: 64-bit adder that time-shares one 16-bit carry-lookahead
// adder (cla16) over four chunks, least significant chunk first.
// Handshake: an operand pair transfers on a rising edge where
// in_valid & in_ready; a result transfers on a rising edge where
// out_valid & out_ready. out_valid and the result stay stable until taken.
// Optional feature macro: ADD_SEQ_SUB_EN adds the 'sub' port (a - b).
// dbg_state exposes the FSM state (0 = IDLE, 1 = SEQ, 2 = DONE).

module cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;

    assign g = x & y;
    assign p = x ^ y;

    // Two-level lookahead: group generate/propagate, group carries, bit carries.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])   | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign s    = p ^ c;
    assign cout = gg[3] | (gp[3] & gc[3]);
endmodule

module add_seq64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
`ifdef ADD_SEQ_SUB_EN
    input  logic        sub,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic        cout,
    output logic        ovf,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] a_q;
    logic [63:0] beff_q;
    logic [1:0]  cnt;
    logic        carry_q;
    logic        sub_c;
    logic [15:0] chunk_a;
    logic [15:0] chunk_b;
    logic [15:0] cla_s;
    logic        cla_cout;
    logic        accept;

`ifdef ADD_SEQ_SUB_EN
    assign sub_c = sub;
`else
    assign sub_c = 1'b0;
`endif

    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SEQ;
            end
            SEQ: begin
                busy = 1'b1;
                if (cnt == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg_state = state;

    // Select the current 16-bit chunk of both operands.
    always_comb begin
        chunk_a = a_q[15:0];
        chunk_b = beff_q[15:0];
        case (cnt)
            2'd0: begin chunk_a = a_q[15:0];  chunk_b = beff_q[15:0];  end
            2'd1: begin chunk_a = a_q[31:16]; chunk_b = beff_q[31:16]; end
            2'd2: begin chunk_a = a_q[47:32]; chunk_b = beff_q[47:32]; end
            default: begin chunk_a = a_q[63:48]; chunk_b = beff_q[63:48]; end
        endcase
    end

    // The carry register holds the initial carry for chunk 0 and the
    // previous chunk's carry-out afterwards.
    cla16 u_cla (
        .x    (chunk_a),
        .y    (chunk_b),
        .cin  (carry_q),
        .s    (cla_s),
        .cout (cla_cout)
    );

    // Operand capture and chunk-by-chunk result accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            beff_q  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_q     <= a;
                beff_q  <= sub_c ? ~b : b;
                carry_q <= sub_c;
                cnt     <= '0;
            end else if (state == SEQ) begin
                sum[{cnt, 4'b0000} +: 16] <= cla_s;
                carry_q <= cla_cout;
                cnt     <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    cout <= cla_cout;
                    ovf  <= (a_q[63] == beff_q[63]) & (cla_s[15] != a_q[63]);
                end
            end
        end
    end
endmodule

// File: tb/tb_add_seq64.sv
// Bench for add_seq64: directed vectors, randomized operations against a
// plain-arithmetic reference, back-pressure, back-to-back spacing and
// reset abort. Define ADD_SEQ_SUB_EN to also exercise subtraction.

module tb_add_seq64;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [65:0] exp_q[$];

    add_seq64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: wide add of a, effective b and initial carry; overflow when
    // both operands share a sign the result does not.
    function automatic logic [65:0] ref_calc(input logic [63:0] ra, input logic [63:0] rb,
                                             input logic rs);
        logic [63:0] bb;
        logic [64:0] t;
        logic        o;
        bb = rs ? ~rb : rb;
        t  = {1'b0, ra} + {1'b0, bb} + {64'd0, rs};
        o  = (ra[63] == bb[63]) && (t[63] != ra[63]);
        return {t[63:0], t[64], o};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One full operation with expected {sum,cout,ovf}; hold = DONE cycles
    // with out_ready low before the result is taken.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                          input logic [65:0] expv, input int hold, input string name);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept_ready got=%b want=1", name, in_ready);
        end
        a = ta; b = tb; sub_i = ts; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = rnd64(); b = rnd64(); sub_i = ~ts;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (cyc == 5) || busy !== (cyc < 5)) begin
                bad++;
                $display("FAIL %s latency cyc=%0d out_valid=%b busy=%b want out_valid=%b busy=%b",
                         name, cyc, out_valid, busy, (cyc == 5), (cyc < 5));
            end
        end
        total++;
        if ({sum, cout, ovf} !== expv) begin
            bad++;
            $display("FAIL %s result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, expv[65:2], expv[1], expv[0]);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1)); a = rnd64(); b = rnd64();
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, ovf} !== expv) begin
                bad++;
                $display("FAIL %s hold i=%0d out_valid=%b in_ready=%b sum=%h want valid=1 ready=0 sum=%h",
                         name, i, out_valid, in_ready, sum, expv[65:2]);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 64'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_state ready=%b valid=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, {64'h0000_0000_0001_0000, 1'b0, 1'b0}, 0, "chunk_carry");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {64'h0, 1'b1, 1'b0}, 0, "full_ripple");
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {64'h8000_0000_0000_0000, 1'b0, 1'b1}, 0, "pos_ovf");
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {64'h0, 1'b1, 1'b1}, 0, "neg_ovf");
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_sub();
        run_op(64'd5, 64'd7, 1'b1, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}, 0, "sub_borrow");
        run_op(64'd7, 64'd5, 1'b1, {64'd2, 1'b1, 1'b0}, 0, "sub_noborrow");
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rs;
            ra = rnd64(); rb = rnd64();
            if (n % 4 == 1) rb = ~ra;
            if (n % 4 == 2) ra[62:0] = '1;
`ifdef ADD_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, ref_calc(ra, rb, rs), 0, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ra;
        logic [63:0] rb;
        ra = rnd64(); rb = rnd64();
        run_op(ra, rb, 1'b0, ref_calc(ra, rb, 1'b0), 10, "backpressure");
        ra = rnd64(); rb = rnd64();
        run_op(ra, rb, 1'b0, ref_calc(ra, rb, 1'b0), 0, "after_backpressure");
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [65:0] e;
        out_ready = 1'b1; in_valid = 1'b1; a = rnd64(); b = rnd64(); sub_i = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_result sum=%h want no result", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf} !== e) begin
                        bad++;
                        $display("FAIL b2b_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e[65:2], e[1], e[0]);
                    end
                end
            end
            if (in_ready === 1'b1 && cyc < 32) begin
                exp_q.push_back(ref_calc(a, b, 1'b0));
                acc_cyc.push_back(cyc);
            end
            if (cyc >= 31) in_valid = 1'b0;
            @(posedge clk);
            #1;
            a = rnd64(); b = rnd64();
        end
        in_valid = 1'b0;
        total++;
        if (exp_q.size() != 0 || acc_cyc.size() < 4) begin
            bad++;
            $display("FAIL b2b_drain left=%0d accepts=%0d want left=0 accepts>=4",
                     exp_q.size(), acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d want=6", acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_seq();
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || sum !== 64'd0) begin
            bad++;
            $display("FAIL abort_state ready=%b busy=%b valid=%b sum=%h want 1 0 0 0",
                     in_ready, busy, out_valid, sum);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_result i=%0d out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_seq();
        run_op(64'd3, 64'd4, 1'b0, {64'd7, 1'b0, 1'b0}, 0, "after_abort");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
